cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares the single main-memory port between the instruction cache and the data cache.
- Sequences each cache miss as an optional dirty-victim write-back followed by a refill read, all over one request/ready memory handshake.
- Sits between both 2-way set-associative caches and main memory.
- Returns refill data and a one-cycle done pulse to the requesting cache.

Parameters:
- ADDR_W, 32, address width of requester and memory ports.
- DATA_W, 32, word width of all data buses.
- FIXED_PRIO, 0, 0 = round-robin between the two caches; 1 = data cache always wins ties.

Ports:
- clk  in  1  single clock, rising-edge.
- reset  in  1  synchronous, active-high.
- i_req  in  1  instruction cache miss request, held until i_done.
- i_addr  in  ADDR_W  refill address (word aligned).
- i_rdata  out  DATA_W  refill data, valid with i_done.
- i_done  out  1  one-cycle pulse, transaction complete.
- d_req  in  1  data cache miss request, held until d_done.
- d_wb  in  1  victim is dirty; write-back required first; sampled with d_req.
- d_wb_addr  in  ADDR_W  victim address.
- d_wb_data  in  DATA_W  victim data.
- d_addr  in  ADDR_W  refill address.
- d_rdata  out  DATA_W  refill data, valid with d_done.
- d_done  out  1  one-cycle pulse.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_ready  in  1  memory completes the access this cycle; any latency of 1 cycle or more.
- mem_rdata  in  DATA_W  read data, valid with mem_ready on reads.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, last_grant = instruction cache (so data cache wins the first tie).
- FSM states: IDLE, WB, RD, DONE.
- IDLE:
  - Selects a requester: a single request wins.
  - With both pending: FIXED_PRIO=1 picks the data cache; FIXED_PRIO=0 picks the requester not served last.
  - Latches owner, addresses, wdata and wb flag into registers; inputs are ignored after this.
  - Next cycle: WB if the data cache owns and wb=1, else RD.
- WB:
  - Drives mem_req=1, mem_we=1, mem_addr=wb_addr, mem_wdata=wb_data.
  - On mem_ready: goes to RD.
- RD:
  - Drives mem_req=1, mem_we=0, mem_addr=refill addr.
  - On mem_ready: captures mem_rdata and goes to DONE.
- DONE:
  - Pulses the owner's done for exactly 1 cycle with its rdata; the other done stays 0.
  - Updates last_grant and returns to IDLE.
- Memory outputs: registered; mem_req is 0 in IDLE and DONE. mem_addr/mem_wdata/mem_we hold stable while mem_req=1 and mem_ready=0.
- Latency:
  - Minimum, no write-back: req sampled at cycle N, mem_req at N+1, done at N+2 when mem_ready arrives at N+1.
  - Each write-back adds ≥1 cycle.
- Request timing: the requester must deassert req on the cycle after done. A req still high in IDLE is treated as a new request. The non-owner's req stays pending, with no starvation under round-robin.
- i_rdata/d_rdata: hold the last captured value until the next refill for that port.
- mem_ready outside WB/RD: ignored.
- Reset mid-transaction: immediately returns to IDLE and drops mem_req; no done is issued and the owner must re-request.
- d_wb with i ownership: not applicable; the instruction cache never writes back.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_i_cnt[31:0] and perf_d_cnt[31:0], counting completed transactions per port.
  - Adds perf_wb_cnt[31:0], counting write-backs.
  - Adds perf_wait_cnt[31:0], counting cycles where a request is pending but not owned.
  - All counters clear on reset and wrap modulo 2^32.
- When undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package cache_pkg:
  - FSM state enum (IDLE/WB/RD/DONE).
  - Owner encoding constants (OWN_I=0, OWN_D=1).
  - Default ADDR_W/DATA_W constants.
- One natural sub-module, rr_arbiter2: a 2-input grant selector holding last_grant and FIXED_PRIO logic, with a combinational grant plus registered last_grant update.

Test Plan:
1. Reset, then i_req=1, i_addr=0x100; memory answers mem_rdata=0xDEADBEEF with 1-cycle ready -> mem_we=0, mem_addr=0x100; i_done pulses once with i_rdata=0xDEADBEEF; d_done stays 0.
2. d_req=1, d_wb=1, d_wb_addr=0x40, d_wb_data=0x12345678, d_addr=0x80; memory has 3-cycle ready latency -> a write to 0x40 with data held stable 3 cycles, then a read of 0x80; d_done fires once; perf_wb_cnt=1 with the macro defined.
3. i_req and d_req asserted together after reset, FIXED_PRIO=0 -> data cache served first, then instruction cache; repeat the tie -> data cache served first again (the last-served port just completed was the instruction cache).
4. FIXED_PRIO=1, d_req held continuously for 4 transactions with i_req high -> all 4 grants go to the data cache; perf_wait_cnt increments every cycle i_req waits.
5. Assert reset during WB with mem_ready=0 -> next cycle mem_req=0, busy=0, no done pulse; re-request completes normally.
6. mem_ready pulsed while in IDLE -> no state change, no done.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared types and constants for the cache/memory arbiter.
package cache_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Owner encoding shared by the arbiter and the transaction sequencer.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input grant selector (instruction vs data cache).
// The grant is combinational; last_grant is updated when a transaction completes.
module rr_arbiter2
    import cache_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    input  logic req_d,
    input  logic update,
    input  logic served,
    output logic grant_valid,
    output logic grant
);

    logic last_grant_q, last_grant_d;

    // Pick a winner; on a tie use fixed priority or the port not served last.
    always_comb begin
        // NOTE: every output is given a value before any branch, so no path can infer a latch.
        grant_valid  = req_i | req_d;
        grant        = OWN_I;
        last_grant_d = last_grant_q;
        if (req_i && req_d) begin
            if (FIXED_PRIO != 0) begin
                grant = OWN_D;
            end else begin
                grant = (last_grant_q == OWN_I) ? OWN_D : OWN_I;
            end
        end else if (req_d) begin
            grant = OWN_D;
        end
        if (update) begin
            last_grant_d = served;
        end
    end

    // Remember which port was served last; the data cache wins the first tie.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values.
        if (reset) begin
            last_grant_q <= OWN_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory port between I-cache and D-cache misses.
// Each miss is an optional dirty-victim write-back followed by a refill read.
// Optional macro ARB_PERF_CNT_EN adds per-port, write-back and wait counters.
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_wb,
    input  logic [ADDR_W-1:0] d_wb_addr,
    input  logic [DATA_W-1:0] d_wb_data,
    input  logic [ADDR_W-1:0] d_addr,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       perf_i_cnt,
    output logic [31:0]       perf_d_cnt,
    output logic [31:0]       perf_wb_cnt,
    output logic [31:0]       perf_wait_cnt,
`endif
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              grant_valid, grant, arb_update;

    rr_arbiter2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .clk        (clk),
        .reset      (reset),
        .req_i      (i_req),
        .req_d      (d_req),
        .update     (arb_update),
        .served     (owner_q),
        .grant_valid(grant_valid),
        .grant      (grant)
    );

    // Transaction sequencing: latch the winner in IDLE, then write-back, refill, done.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rd_addr_d   = rd_addr_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        arb_update  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d   = grant;
                    mem_req_d = 1'b1;
                    if (grant == OWN_D) begin
                        rd_addr_d = d_addr;
                        if (d_wb) begin
                            state_d     = WB;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = d_wb_addr;
                            mem_wdata_d = d_wb_data;
                        end else begin
                            state_d    = RD;
                            mem_we_d   = 1'b0;
                            mem_addr_d = d_addr;
                        end
                    end else begin
                        rd_addr_d  = i_addr;
                        state_d    = RD;
                        mem_we_d   = 1'b0;
                        mem_addr_d = i_addr;
                    end
                end
            end
            WB: begin
                if (mem_ready) begin
                    state_d    = RD;
                    mem_we_d   = 1'b0;
                    mem_addr_d = rd_addr_q;
                end
            end
            RD: begin
                if (mem_ready) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_D) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        i_rdata_d = mem_rdata;
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                arb_update = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state, registered memory-side outputs and refill data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_I;
            rd_addr_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rd_addr_q   <= rd_addr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_done    = (state_q == DONE) && (owner_q == OWN_I);
    assign d_done    = (state_q == DONE) && (owner_q == OWN_D);
    assign busy      = (state_q != IDLE);

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_i_cnt_q, perf_i_cnt_d;
    logic [31:0] perf_d_cnt_q, perf_d_cnt_d;
    logic [31:0] perf_wb_cnt_q, perf_wb_cnt_d;
    logic [31:0] perf_wait_cnt_q, perf_wait_cnt_d;
    logic        waiting;

    // A request waits when it loses an IDLE tie or arrives while the other port owns memory.
    always_comb begin
        if (state_q == IDLE) begin
            waiting = i_req & d_req;
        end else begin
            waiting = (owner_q == OWN_I) ? d_req : i_req;
        end
        perf_i_cnt_d    = perf_i_cnt_q + {31'd0, i_done};
        perf_d_cnt_d    = perf_d_cnt_q + {31'd0, d_done};
        perf_wb_cnt_d   = perf_wb_cnt_q + {31'd0, (state_q == WB) && mem_ready};
        perf_wait_cnt_d = perf_wait_cnt_q + {31'd0, waiting};
    end

    // Free-running counters that wrap modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_i_cnt_q    <= '0;
            perf_d_cnt_q    <= '0;
            perf_wb_cnt_q   <= '0;
            perf_wait_cnt_q <= '0;
        end else begin
            perf_i_cnt_q    <= perf_i_cnt_d;
            perf_d_cnt_q    <= perf_d_cnt_d;
            perf_wb_cnt_q   <= perf_wb_cnt_d;
            perf_wait_cnt_q <= perf_wait_cnt_d;
        end
    end

    assign perf_i_cnt    = perf_i_cnt_q;
    assign perf_d_cnt    = perf_d_cnt_q;
    assign perf_wb_cnt   = perf_wb_cnt_q;
    assign perf_wait_cnt = perf_wait_cnt_q;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: randomized self-checking bench. Instance 0 is round-robin,
// instance 1 uses fixed data-cache priority. A transaction-level model predicts the
// memory accesses, done pulses and refill data cycle by cycle.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset     [2];
    logic        i_req     [2];
    logic [31:0] i_addr    [2];
    logic [31:0] i_rdata   [2];
    logic        i_done    [2];
    logic        d_req     [2];
    logic        d_wb      [2];
    logic [31:0] d_wb_addr [2];
    logic [31:0] d_wb_data [2];
    logic [31:0] d_addr    [2];
    logic [31:0] d_rdata   [2];
    logic        d_done    [2];
    logic        mem_req   [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic        mem_ready [2];
    logic [31:0] mem_rdata [2];
    logic        busy      [2];
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_i_cnt    [2];
    logic [31:0] perf_d_cnt    [2];
    logic [31:0] perf_wb_cnt   [2];
    logic [31:0] perf_wait_cnt [2];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(g)) u_dut (
            .clk          (clk),
            .reset        (reset[g]),
            .i_req        (i_req[g]),
            .i_addr       (i_addr[g]),
            .i_rdata      (i_rdata[g]),
            .i_done       (i_done[g]),
            .d_req        (d_req[g]),
            .d_wb         (d_wb[g]),
            .d_wb_addr    (d_wb_addr[g]),
            .d_wb_data    (d_wb_data[g]),
            .d_addr       (d_addr[g]),
            .d_rdata      (d_rdata[g]),
            .d_done       (d_done[g]),
            .mem_req      (mem_req[g]),
            .mem_we       (mem_we[g]),
            .mem_addr     (mem_addr[g]),
            .mem_wdata    (mem_wdata[g]),
            .mem_ready    (mem_ready[g]),
            .mem_rdata    (mem_rdata[g]),
`ifdef ARB_PERF_CNT_EN
            .perf_i_cnt   (perf_i_cnt[g]),
            .perf_d_cnt   (perf_d_cnt[g]),
            .perf_wb_cnt  (perf_wb_cnt[g]),
            .perf_wait_cnt(perf_wait_cnt[g]),
`endif
            .busy         (busy[g])
        );
    end

    // Requester jobs and expected memory accesses.
    typedef struct {
        logic [31:0] addr;
        logic        wb;
        logic [31:0] wb_addr;
        logic [31:0] wb_data;
    } job_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    job_t        iq[$];
    job_t        dq[$];
    acc_t        accq[$];
    bit          served_q[$];
    logic [31:0] mem_m [logic [31:0]];
    logic [31:0] rdata_m [2];
    bit          done_exp;
    bit          own_m;
    bit          last_served;
    int          acc_cnt, acc_lat, lat_min, lat_max;
    bit          noise;
    int unsigned i_cnt_m, d_cnt_m, wb_cnt_m, wait_m;
    int          errors, checks;

    function automatic logic [31:0] read_mem(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic job_t rand_job();
        job_t j;
        j.addr    = 32'($urandom_range(0, 15)) << 2;
        j.wb      = 1'($urandom_range(0, 1));
        j.wb_addr = 32'($urandom_range(0, 15)) << 2;
        j.wb_data = $urandom;
        return j;
    endfunction

    function automatic int pick_lat();
        return int'($urandom_range(lat_max, lat_min));
    endfunction

    task automatic model_reset();
        accq.delete();
        done_exp    = 1'b0;
        own_m       = 1'b0;
        last_served = 1'b0;
        rdata_m[0]  = '0;
        rdata_m[1]  = '0;
        acc_cnt     = 0;
        i_cnt_m     = 0;
        d_cnt_m     = 0;
        wb_cnt_m    = 0;
        wait_m      = 0;
    endtask

    // Compare the DUT's outputs for the current cycle with the model.
    task automatic check_cycle(input int k);
        logic [3:0] got, exp;
        bit         acc;
        acc = (accq.size() > 0) && !done_exp;
        exp = {done_exp && !own_m, done_exp && own_m, done_exp || acc, acc};
        got = {i_done[k], d_done[k], busy[k], mem_req[k]};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL ctrl inst=%0d t=%0t {i_done,d_done,busy,mem_req} got=%b exp=%b", k, $time, got, exp);
        end
        checks++;
        if (i_rdata[k] !== rdata_m[0] || d_rdata[k] !== rdata_m[1]) begin
            errors++;
            $display("FAIL rdata inst=%0d t=%0t i_rdata=%h exp=%h d_rdata=%h exp=%h",
                     k, $time, i_rdata[k], rdata_m[0], d_rdata[k], rdata_m[1]);
        end
        if (acc) begin
            checks++;
            if (mem_we[k] !== accq[0].we || mem_addr[k] !== accq[0].addr ||
                (accq[0].we && mem_wdata[k] !== accq[0].wdata)) begin
                errors++;
                $display("FAIL access inst=%0d t=%0t we/addr/wdata got=%b/%h/%h exp=%b/%h/%h", k, $time,
                         mem_we[k], mem_addr[k], mem_wdata[k], accq[0].we, accq[0].addr, accq[0].wdata);
            end
        end
    endtask

    // Requesters and memory: choose this cycle's inputs.
    task automatic drive(input int k);
        bit busy_m;
        if (done_exp) begin
            served_q.push_back(own_m);
            if (own_m) begin
                dq.delete(0);
                d_cnt_m++;
            end else begin
                iq.delete(0);
                i_cnt_m++;
            end
        end
        i_req[k] = (iq.size() > 0);
        i_addr[k] = (iq.size() > 0) ? iq[0].addr : $urandom;
        d_req[k] = (dq.size() > 0);
        if (dq.size() > 0) begin
            d_addr[k]    = dq[0].addr;
            d_wb[k]      = dq[0].wb;
            d_wb_addr[k] = dq[0].wb_addr;
            d_wb_data[k] = dq[0].wb_data;
        end else begin
            d_addr[k]    = $urandom;
            d_wb[k]      = 1'($urandom_range(0, 1));
            d_wb_addr[k] = $urandom;
            d_wb_data[k] = $urandom;
        end
        if (accq.size() > 0 && !done_exp) begin
            mem_ready[k] = (acc_cnt >= acc_lat - 1);
            mem_rdata[k] = (mem_ready[k] && !accq[0].we) ? read_mem(accq[0].addr) : $urandom;
        end else begin
            mem_ready[k] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata[k] = $urandom;
        end
        busy_m = done_exp || (accq.size() > 0);
        if (!busy_m) begin
            if (i_req[k] && d_req[k]) wait_m++;
        end else if (own_m ? i_req[k] : d_req[k]) begin
            wait_m++;
        end
    endtask

    // Advance the transaction model by one clock.
    task automatic advance(input int k, input bit rst);
        if (rst) begin
            model_reset();
        end else if (done_exp) begin
            last_served = own_m;
            done_exp    = 1'b0;
        end else if (accq.size() > 0) begin
            if (mem_ready[k]) begin
                if (accq[0].we) begin
                    mem_m[accq[0].addr] = accq[0].wdata;
                    wb_cnt_m++;
                end else begin
                    rdata_m[own_m] = read_mem(accq[0].addr);
                end
                accq.delete(0);
                acc_cnt = 0;
                acc_lat = pick_lat();
                if (accq.size() == 0) done_exp = 1'b1;
            end else begin
                acc_cnt++;
            end
        end else if (i_req[k] || d_req[k]) begin
            if (i_req[k] && d_req[k]) begin
                own_m = (k == 1) ? 1'b1 : !last_served;
            end else begin
                own_m = d_req[k];
            end
            if (own_m) begin
                if (d_wb[k]) accq.push_back('{we: 1'b1, addr: d_wb_addr[k], wdata: d_wb_data[k]});
                accq.push_back('{we: 1'b0, addr: d_addr[k], wdata: 32'h0});
            end else begin
                accq.push_back('{we: 1'b0, addr: i_addr[k], wdata: 32'h0});
            end
            acc_cnt = 0;
            acc_lat = pick_lat();
        end
    endtask

    task automatic cycle(input int k, input bit rst);
        check_cycle(k);
        drive(k);
        reset[k] = rst;
        if (rst) mem_ready[k] = 1'b0;
        advance(k, rst);
        @(negedge clk);
    endtask

    task automatic run_until_idle(input int k, input int budget);
        int n;
        n = 0;
        while ((iq.size() > 0 || dq.size() > 0 || accq.size() > 0 || done_exp) && n < budget) begin
            cycle(k, 1'b0);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL timeout inst=%0d cycles=%0d limit=%0d", k, n, budget);
        end
        repeat (2) cycle(k, 1'b0);
    endtask

    task automatic do_reset(input int k);
        iq.delete();
        dq.delete();
        served_q.delete();
        reset[k]     = 1'b1;
        i_req[k]     = 1'b0;
        d_req[k]     = 1'b0;
        mem_ready[k] = 1'b0;
        @(negedge clk);
        reset[k] = 1'b0;
        model_reset();
    endtask

    task automatic check_perf(input int k);
`ifdef ARB_PERF_CNT_EN
        checks++;
        if (perf_i_cnt[k] !== i_cnt_m || perf_d_cnt[k] !== d_cnt_m ||
            perf_wb_cnt[k] !== wb_cnt_m || perf_wait_cnt[k] !== wait_m) begin
            errors++;
            $display("FAIL perf inst=%0d got i/d/wb/wait=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", k,
                     perf_i_cnt[k], perf_d_cnt[k], perf_wb_cnt[k], perf_wait_cnt[k],
                     i_cnt_m, d_cnt_m, wb_cnt_m, wait_m);
        end
`else
        if (k < 0) $display("perf counters not built");
`endif
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1'b0;
            checks++;
            if (mem_req[k] !== 1'b0 || mem_we[k] !== 1'b0 || mem_addr[k] !== 32'h0 ||
                mem_wdata[k] !== 32'h0 || i_done[k] !== 1'b0 || d_done[k] !== 1'b0 ||
                busy[k] !== 1'b0 || i_rdata[k] !== 32'h0 || d_rdata[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset_values inst=%0d req=%b we=%b addr=%h wdata=%h done=%b%b busy=%b rdata=%h/%h exp all zero",
                         k, mem_req[k], mem_we[k], mem_addr[k], mem_wdata[k], i_done[k], d_done[k],
                         busy[k], i_rdata[k], d_rdata[k]);
            end
        end
        model_reset();
    endtask

    task automatic test_single_refill();
        do_reset(0);
        noise   = 1'b0;
        lat_min = 1;
        lat_max = 1;
        mem_m[32'h100] = 32'hDEADBEEF;
        iq.push_back('{addr: 32'h100, wb: 1'b0, wb_addr: 32'h0, wb_data: 32'h0});
        run_until_idle(0, 20);
        checks++;
        if (i_rdata[0] !== 32'hDEADBEEF || served_q.size() != 1) begin
            errors++;
            $display("FAIL single_refill i_rdata=%h exp=deadbeef served=%0d exp=1", i_rdata[0], served_q.size());
        end
        check_perf(0);
    endtask

    task automatic test_writeback();
        do_reset(0);
        noise   = 1'b0;
        lat_min = 3;
        lat_max = 3;
        mem_m[32'h80] = 32'h0BADF00D;
        dq.push_back('{addr: 32'h80, wb: 1'b1, wb_addr: 32'h40, wb_data: 32'h12345678});
        run_until_idle(0, 30);
        checks++;
        if (d_rdata[0] !== 32'h0BADF00D || i_rdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL writeback d_rdata=%h exp=0badf00d i_rdata=%h exp=0", d_rdata[0], i_rdata[0]);
        end
        check_perf(0);
    endtask

    task automatic test_tie_rr();
        do_reset(0);
        noise   = 1'b1;
        lat_min = 1;
        lat_max = 2;
        for (int r = 0; r < 2; r++) begin
            served_q.delete();
            iq.push_back(rand_job());
            dq.push_back(rand_job());
            run_until_idle(0, 40);
            checks++;
            if (served_q.size() != 2 || served_q[0] !== 1'b1 || served_q[1] !== 1'b0) begin
                errors++;
                $display("FAIL tie_rr round=%0d order(d=1) got=%b%b n=%0d exp=10 n=2",
                         r, served_q[0], served_q[1], served_q.size());
            end
        end
        check_perf(0);
    endtask

    task automatic test_fixed_prio();
        bit exp_order[5];
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset(1);
        noise   = 1'b0;
        lat_min = 1;
        lat_max = 3;
        iq.push_back(rand_job());
        repeat (4) dq.push_back(rand_job());
        run_until_idle(1, 100);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (served_q.size() != 5 || served_q[i] !== exp_order[i]) begin
                errors++;
                $display("FAIL fixed_prio slot=%0d got=%b exp=%b n=%0d", i, served_q[i], exp_order[i], served_q.size());
            end
        end
        check_perf(1);
    endtask

    task automatic test_reset_mid_wb();
        do_reset(0);
        noise   = 1'b0;
        lat_min = 20;
        lat_max = 20;
        dq.push_back('{addr: 32'h200, wb: 1'b1, wb_addr: 32'h300, wb_data: 32'hCAFEF00D});
        repeat (3) cycle(0, 1'b0);
        cycle(0, 1'b1);
        checks++;
        if (mem_req[0] !== 1'b0 || busy[0] !== 1'b0 || i_done[0] !== 1'b0 || d_done[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wb mem_req=%b busy=%b done=%b%b exp all 0", mem_req[0], busy[0], i_done[0], d_done[0]);
        end
        lat_min = 1;
        lat_max = 3;
        run_until_idle(0, 40);
        checks++;
        if (served_q.size() != 1 || d_rdata[0] !== read_mem(32'h200)) begin
            errors++;
            $display("FAIL rerequest served=%0d exp=1 d_rdata=%h exp=%h", served_q.size(), d_rdata[0], read_mem(32'h200));
        end
        check_perf(0);
    endtask

    task automatic test_idle_ready();
        noise = 1'b1;
        repeat (12) cycle(0, 1'b0);
        check_perf(0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 2; k++) begin
            do_reset(k);
            noise   = 1'b1;
            lat_min = 1;
            lat_max = 4;
            for (int r = 0; r < 12; r++) begin
                repeat ($urandom_range(0, 2)) iq.push_back(rand_job());
                repeat ($urandom_range(0, 2)) dq.push_back(rand_job());
                run_until_idle(k, 200);
            end
            check_perf(k);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        noise  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            reset[k]     = 1'b1;
            i_req[k]     = 1'b0;
            i_addr[k]    = '0;
            d_req[k]     = 1'b0;
            d_wb[k]      = 1'b0;
            d_wb_addr[k] = '0;
            d_wb_data[k] = '0;
            d_addr[k]    = '0;
            mem_ready[k] = 1'b0;
            mem_rdata[k] = '0;
        end
        @(negedge clk);
        test_reset();
        test_single_refill();
        test_writeback();
        test_tie_rr();
        test_fixed_prio();
        test_reset_mid_wb();
        test_idle_ready();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
